sdram_loader: RTL
=================

Name: sdram_loader

Overview:
Upstream producer for one channel of the dual-port SDRAM controller. It takes a byte stream from the MCU/SPI side with valid/ready, packs pairs of bytes little-endian into 16-bit words, and writes them to consecutive word addresses using the channel's toggle req/ack handshake. It is used to load PRG/CHR images into SDRAM before the cartridge starts running.

Parameters:
ADDR_BITS, 23, word-address width of the SDRAM channel
PAD_BYTE, 8'hFF, upper byte written when flush leaves an odd trailing byte

Ports:
clk  in  1  system clock (same clock as the SDRAM controller)
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: latch base_addr, clear word_count, enter load; ignored while busy
base_addr  in  ADDR_BITS  first word address of the image
s_data  in  8  stream byte
s_valid  in  1  s_data valid
s_ready  out  1  byte accepted on a clk edge when s_valid && s_ready
flush  in  1  one-cycle pulse: end of stream; pad, drain, finish
busy  out  1  high from the start acceptance until done
done  out  1  one-cycle pulse after the last write is acknowledged
word_count  out  ADDR_BITS+1  words written since start
verify_err  out  1  sticky verify mismatch (see Optional Feature)
ram_req  out  1  channel request; toggled to issue a transaction
ram_ack  in  1  channel acknowledge; transaction is complete when ram_ack == ram_req
ram_we  out  1  1 = write, 0 = read
ram_address  out  ADDR_BITS  word address
ram_data_write  out  16  write data
ram_data_read  in  16  read data; valid when ram_ack == ram_req

Behaviour:
- Reset values: ram_req=0, ram_we=0, ram_address=0, ram_data_write=0, s_ready=0, busy=0, done=0, word_count=0, verify_err=0. State goes to IDLE and all buffers are emptied.
- Buffering:
  - Assembly register holds a low byte plus a have_lo flag.
  - Pending word register holds a pend_valid flag.
  - An in-flight transaction is tracked by ram_req != ram_ack.
- s_ready = busy && !flushing && !(have_lo && pend_valid).
- The 1st byte of a pair goes to data[7:0] and the 2nd to data[15:8]. When the 2nd byte is accepted, the word moves to pending.
- Issue rule: if pend_valid and the channel is idle (ram_req == ram_ack), then on the next edge:
  - drive ram_we=1, ram_address=cur_addr, ram_data_write=pending;
  - toggle ram_req and clear pend_valid.
  - Latency: 1 clk from acceptance of the 2nd byte to the ram_req toggle.
- ram_we, ram_address and ram_data_write are held stable while ram_req != ram_ack.
- On ack (ram_req becomes equal to ram_ack): cur_addr increments and word_count increments.
- Address wrap: cur_addr wraps from 2^ADDR_BITS-1 to 0 silently. word_count does not wrap.
- States:
  - IDLE: on start, if ram_req == ram_ack, latch base_addr, go to LOAD and set busy=1. Otherwise ignore start.
  - LOAD: accept bytes and issue writes. On flush, go to DRAIN.
  - DRAIN: if have_lo, form {PAD_BYTE, lo} and push it to pending once the slot is free. Wait until have_lo=0, pend_valid=0 and ram_req == ram_ack, then go to FINISH.
  - FINISH: pulse done for 1 cycle, set busy=0, return to IDLE.
- Simultaneous events:
  - flush with an accepted s_valid byte: the byte is accepted first, then flush applies.
  - flush with nothing buffered: done is asserted 1–2 cycles later and word_count is unchanged.
  - flush while in IDLE: ignored.
- Reset mid-transaction: all outputs return to their reset values. The controller shares the reset, so the channel starts with req == ack. After reset, start is only honoured when ram_req == ram_ack.

Optional Feature:
Macro SDRAM_LOADER_VERIFY_EN.
- When defined, each acknowledged write is followed by a read of the same address:
  - ram_we=0, toggle ram_req, wait for ack;
  - compare ram_data_read with the written word;
  - on mismatch, set verify_err (sticky until the next start).
- The address increments only after the verify ack. s_ready still follows the buffer rule, so bytes keep buffering during the verify.
- When not defined, no reads are issued and verify_err is tied to 0.

Test Plan:
- start base_addr=0x000010; bytes 11,22,33,44; flush -> writes 0x2211@0x000010 and 0x4433@0x000011; done pulse; word_count=2; busy falls with done.
- Bytes AA,BB,CC then flush -> writes 0xBBAA and then 0xFFCC at consecutive addresses; word_count=2.
- Model holds ack for 20 cycles and 8 bytes are offered back-to-back -> s_ready drops when have_lo && pend_valid; all 4 words land in order with no lost or duplicated bytes; ram outputs stay stable while req != ack.
- base_addr=0x7FFFFF, 4 bytes -> writes at 0x7FFFFF and then 0x000000; word_count=2.
- rst_n pulsed low while a write is in flight -> every output at its reset value; a new start plus 2 bytes writes correctly afterwards.
- With SDRAM_LOADER_VERIFY_EN, model corrupts the read-back of the 2nd word -> verify_err=1 after that read's ack; done still pulses; the next start clears verify_err.

Source files
------------

// File: rtl/sdram_loader.sv
// rtl/sdram_loader.sv - byte stream to 16-bit SDRAM word writer over a toggle req/ack channel
// Purpose: packs an 8-bit valid/ready stream little-endian into 16-bit words and
//   writes them to consecutive word addresses starting at base_addr.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   start, base_addr, flush       load control (start latches base, flush ends the image)
//   s_data, s_valid, s_ready      byte stream in
//   busy, done, word_count        load status
//   verify_err                    sticky read-back mismatch (0 unless verify is built in)
//   ram_req/ram_ack/ram_we/ram_address/ram_data_write/ram_data_read
//                                 one channel of the SDRAM controller, toggle handshake
// Option: define SDRAM_LOADER_VERIFY_EN to read back and compare every written word.
module sdram_loader #(
  parameter int unsigned ADDR_BITS = 23,
  parameter logic [7:0]  PAD_BYTE  = 8'hFF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 flush,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS:0]   word_count,
  output logic                 verify_err,
  output logic                 ram_req,
  input  logic                 ram_ack,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_address,
  output logic [15:0]          ram_data_write,
  input  logic [15:0]          ram_data_read
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [ADDR_BITS:0]   CNT_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [7:0]             lo_q, lo_d;
  logic                   have_lo_q, have_lo_d;
  logic [15:0]            pend_q, pend_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [ADDR_BITS-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_BITS:0]     word_count_q, word_count_d;
  // txn_q marks a transaction we launched and have not yet retired; it lets the
  // ack be seen exactly once even though req == ack persists afterwards.
  logic                   txn_q, txn_d;
  logic                   ram_req_q, ram_req_d;
  logic                   ram_we_q, ram_we_d;
  logic [ADDR_BITS-1:0]   ram_address_q, ram_address_d;
  logic [15:0]            ram_data_write_q, ram_data_write_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   chan_idle;
  logic                   accept;

`ifdef SDRAM_LOADER_VERIFY_EN
  logic                   rd_q, rd_d;
  logic                   verify_err_q, verify_err_d;
  assign verify_err = verify_err_q;
`else
  logic                   unused_ram_data_read;
  assign unused_ram_data_read = ^ram_data_read;
  assign verify_err = 1'b0;
`endif

  assign chan_idle      = (ram_req_q == ram_ack);
  // Stall only when both the half-word and the pending word are occupied.
  assign s_ready        = busy_q && (state_q != ST_DRAIN) && !(have_lo_q && pend_valid_q);
  assign accept         = s_valid && s_ready;

  assign busy           = busy_q;
  assign done           = done_q;
  assign word_count     = word_count_q;
  assign ram_req        = ram_req_q;
  assign ram_we         = ram_we_q;
  assign ram_address    = ram_address_q;
  assign ram_data_write = ram_data_write_q;

  always_comb begin
    state_d          = state_q;
    lo_d             = lo_q;
    have_lo_d        = have_lo_q;
    pend_d           = pend_q;
    pend_valid_d     = pend_valid_q;
    cur_addr_d       = cur_addr_q;
    word_count_d     = word_count_q;
    txn_d            = txn_q;
    ram_req_d        = ram_req_q;
    ram_we_d         = ram_we_q;
    ram_address_d    = ram_address_q;
    ram_data_write_d = ram_data_write_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
`ifdef SDRAM_LOADER_VERIFY_EN
    rd_d             = rd_q;
    verify_err_d     = verify_err_q;
`endif

    // Channel side: retire an acknowledged transaction, else launch the pending word.
    if (txn_q && chan_idle) begin
`ifdef SDRAM_LOADER_VERIFY_EN
      if (!rd_q) begin
        // Write landed: read the same word back; address and data stay put.
        ram_we_d  = 1'b0;
        ram_req_d = ~ram_req_q;
        rd_d      = 1'b1;
      end else begin
        rd_d         = 1'b0;
        txn_d        = 1'b0;
        cur_addr_d   = cur_addr_q + ADDR_ONE;
        word_count_d = word_count_q + CNT_ONE;
        if (ram_data_read != ram_data_write_q) begin
          verify_err_d = 1'b1;
        end
      end
`else
      txn_d        = 1'b0;
      cur_addr_d   = cur_addr_q + ADDR_ONE;
      word_count_d = word_count_q + CNT_ONE;
`endif
    end else if (pend_valid_q && chan_idle && !txn_q) begin
      ram_we_d         = 1'b1;
      ram_address_d    = cur_addr_q;
      ram_data_write_d = pend_q;
      ram_req_d        = ~ram_req_q;
      pend_valid_d     = 1'b0;
      txn_d            = 1'b1;
    end

    // Byte assembly. A second byte is only accepted while pending is empty,
    // so this never collides with the launch above clearing pend_valid.
    if (accept) begin
      if (have_lo_q) begin
        pend_d       = {s_data, lo_q};
        pend_valid_d = 1'b1;
        have_lo_d    = 1'b0;
      end else begin
        lo_d      = s_data;
        have_lo_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start && chan_idle) begin
          state_d      = ST_LOAD;
          busy_d       = 1'b1;
          cur_addr_d   = base_addr;
          word_count_d = '0;
          have_lo_d    = 1'b0;
          pend_valid_d = 1'b0;
`ifdef SDRAM_LOADER_VERIFY_EN
          verify_err_d = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (have_lo_q && !pend_valid_q) begin
          pend_d       = {PAD_BYTE, lo_q};
          pend_valid_d = 1'b1;
          have_lo_d    = 1'b0;
        end
        if (!have_lo_q && !pend_valid_q && chan_idle && !txn_q) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      lo_q             <= '0;
      have_lo_q        <= 1'b0;
      pend_q           <= '0;
      pend_valid_q     <= 1'b0;
      cur_addr_q       <= '0;
      word_count_q     <= '0;
      txn_q            <= 1'b0;
      ram_req_q        <= 1'b0;
      ram_we_q         <= 1'b0;
      ram_address_q    <= '0;
      ram_data_write_q <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
`ifdef SDRAM_LOADER_VERIFY_EN
      rd_q             <= 1'b0;
      verify_err_q     <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      lo_q             <= lo_d;
      have_lo_q        <= have_lo_d;
      pend_q           <= pend_d;
      pend_valid_q     <= pend_valid_d;
      cur_addr_q       <= cur_addr_d;
      word_count_q     <= word_count_d;
      txn_q            <= txn_d;
      ram_req_q        <= ram_req_d;
      ram_we_q         <= ram_we_d;
      ram_address_q    <= ram_address_d;
      ram_data_write_q <= ram_data_write_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
`ifdef SDRAM_LOADER_VERIFY_EN
      rd_q             <= rd_d;
      verify_err_q     <= verify_err_d;
`endif
    end
  end

endmodule
